// File: rtl/mac_tx_framer.sv
// Ethernet MAC transmit framer. It takes a payload byte stream and adds the
// preamble, the SFD, zero padding up to a minimum length and a CRC-32 FCS.
// It enforces an inter-frame gap. If the source stalls mid-frame, it aborts
// the frame and drains the rest of that frame from the source.
module mac_tx_framer #(
  parameter int IFG_BYTES = 12,
  parameter int MIN_FRAME = 60
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        s_valid,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        s_ready,
  output logic        out_txen,
  output logic [7:0]  out_txd,
  output logic        busy,
  output logic        underrun,
  output logic [15:0] frames_sent
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SFD      = 3'd2,
    ST_PAYLOAD  = 3'd3,
    ST_PAD      = 3'd4,
    ST_FCS      = 3'd5,
    ST_DRAIN    = 3'd6,
    ST_IFG      = 3'd7
  } state_t;

  localparam logic [15:0] MIN_LEN       = 16'(MIN_FRAME);
  localparam logic [15:0] IFG_LEN       = 16'(IFG_BYTES);
  localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  // Reflected CRC-32 advanced by one byte, LSB of the byte first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] data);
    logic [31:0] c;
    c = crc_in ^ {24'h00_0000, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  // 16-bit increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

  state_t      state_r;
  logic        s_ready_r;
  logic        out_txen_r;
  logic [7:0]  out_txd_r;
  logic        busy_r;
  logic        underrun_r;
  logic [15:0] frames_sent_r;
  logic [15:0] byte_cnt_r;   // bytes emitted after the SFD, saturating
  logic [15:0] phase_cnt_r;  // position inside preamble / FCS / IFG
  logic [31:0] crc_r;
  logic [31:0] fcs_r;        // complemented CRC, shifted out LSB first

  assign s_ready     = s_ready_r;
  assign out_txen    = out_txen_r;
  assign out_txd     = out_txd_r;
  assign busy        = busy_r;
  assign underrun    = underrun_r;
  assign frames_sent = frames_sent_r;

  // Frame sequencer: the state names what kind of byte is on out_txd this cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      s_ready_r     <= 1'b0;
      out_txen_r    <= 1'b0;
      out_txd_r     <= 8'h00;
      busy_r        <= 1'b0;
      underrun_r    <= 1'b0;
      frames_sent_r <= 16'h0000;
      byte_cnt_r    <= 16'h0000;
      phase_cnt_r   <= 16'h0000;
      crc_r         <= CRC_INIT;
      fcs_r         <= 32'h0000_0000;
    end else begin
      underrun_r <= 1'b0;
      busy_r     <= 1'b1;
      case (state_r)
        ST_IDLE: begin
          s_ready_r   <= 1'b0;
          phase_cnt_r <= 16'h0000;
          byte_cnt_r  <= 16'h0000;
          crc_r       <= CRC_INIT;
          if (s_valid) begin
            state_r    <= ST_PREAMBLE;
            out_txen_r <= 1'b1;
            out_txd_r  <= PREAMBLE_BYTE;
          end else begin
            out_txen_r <= 1'b0;
            out_txd_r  <= 8'h00;
            busy_r     <= 1'b0;
          end
        end
        ST_PREAMBLE: begin
          out_txen_r <= 1'b1;
          if (phase_cnt_r == 16'd6) begin
            state_r   <= ST_SFD;
            out_txd_r <= SFD_BYTE;
            s_ready_r <= 1'b1;
          end else begin
            phase_cnt_r <= phase_cnt_r + 16'd1;
            out_txd_r   <= PREAMBLE_BYTE;
            s_ready_r   <= 1'b0;
          end
        end
        // While s_ready is high the source must deliver. Once the last byte is
        // on the line, pad up to the minimum length and then start the FCS.
        ST_SFD, ST_PAYLOAD, ST_PAD: begin
          if (s_ready_r) begin
            if (s_valid) begin
              state_r    <= ST_PAYLOAD;
              out_txen_r <= 1'b1;
              out_txd_r  <= s_data;
              crc_r      <= crc32_byte(crc_r, s_data);
              byte_cnt_r <= sat_inc(byte_cnt_r);
              s_ready_r  <= ~s_last;
            end else begin
              state_r    <= ST_DRAIN;
              out_txen_r <= 1'b0;
              out_txd_r  <= 8'h00;
              underrun_r <= 1'b1;
              s_ready_r  <= 1'b1;
            end
          end else if (byte_cnt_r < MIN_LEN) begin
            state_r    <= ST_PAD;
            out_txen_r <= 1'b1;
            out_txd_r  <= 8'h00;
            crc_r      <= crc32_byte(crc_r, 8'h00);
            byte_cnt_r <= sat_inc(byte_cnt_r);
            s_ready_r  <= 1'b0;
          end else begin
            state_r     <= ST_FCS;
            out_txen_r  <= 1'b1;
            out_txd_r   <= ~crc_r[7:0];
            fcs_r       <= ~crc_r;
            phase_cnt_r <= 16'h0000;
            s_ready_r   <= 1'b0;
          end
        end
        ST_FCS: begin
          s_ready_r <= 1'b0;
          if (phase_cnt_r == 16'd3) begin
            state_r       <= ST_IFG;
            out_txen_r    <= 1'b0;
            out_txd_r     <= 8'h00;
            frames_sent_r <= frames_sent_r + 16'd1;
            phase_cnt_r   <= 16'd1;
          end else begin
            out_txen_r  <= 1'b1;
            out_txd_r   <= fcs_r[15:8];
            fcs_r       <= fcs_r >> 8;
            phase_cnt_r <= phase_cnt_r + 16'd1;
          end
        end
        ST_DRAIN: begin
          out_txen_r <= 1'b0;
          out_txd_r  <= 8'h00;
          if (s_valid && s_last) begin
            state_r     <= ST_IFG;
            s_ready_r   <= 1'b0;
            phase_cnt_r <= 16'd1;
          end else begin
            s_ready_r <= 1'b1;
          end
        end
        ST_IFG: begin
          out_txen_r <= 1'b0;
          out_txd_r  <= 8'h00;
          s_ready_r  <= 1'b0;
          if (phase_cnt_r >= IFG_LEN) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            phase_cnt_r <= phase_cnt_r + 16'd1;
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          out_txen_r <= 1'b0;
          out_txd_r  <= 8'h00;
          s_ready_r  <= 1'b0;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

endmodule
